// File: rtl/cmsdk_apb_master_pkg.sv
// Shared definitions for the single-outstanding APB3 initiator.
// No logic; state encoding and widths only.
// Imported by the controller top and its wait-state watchdog.
package cmsdk_apb_master_pkg;

    localparam int APB_DATA_W = 32;
    localparam int TMO_CNT_W  = 16;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
    localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        SETUP  = ST_SETUP_ENC,
        ACCESS = ST_ACCESS_ENC,
        RESP   = ST_RESP_ENC
    } state_t;

endpackage

// File: rtl/cmsdk_apb_master_wdog.sv
// Wait-state counter and timeout compare for the APB ACCESS phase.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts while enabled, saturating at all-ones.
module cmsdk_apb_master_wdog
    import cmsdk_apb_master_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 clear,
    input  logic                 cnt_en,
    input  logic [TMO_CNT_W-1:0] timeout_cycles,
    output logic                 expired
);

    logic [TMO_CNT_W-1:0] cnt;

    // Clear loads 1 so the first ACCESS cycle already reads as wait cycle 1.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= TMO_CNT_W'(1);
        end else if (cnt_en && (cnt != '1)) begin
            cnt <= cnt + TMO_CNT_W'(1);
        end
    end

    assign expired = (timeout_cycles != '0) && (cnt == timeout_cycles);

endmodule

// File: rtl/cmsdk_apb_master_ctrl.sv
// APB3 initiator: valid/ready command in, one APB transfer, one response out.
// Latency: zero-wait transfer gives rsp_valid 3 cycles after the command handshake.
// Backpressure: single outstanding; req_ready low until the response is consumed.
module cmsdk_apb_master_ctrl
    import cmsdk_apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [TMO_CNT_W-1:0] TMO = TMO_CNT_W'(TIMEOUT_CYCLES);

    state_t state, next_state;
    logic   hs_req;
    logic   done;
    logic   abort;
    logic   expired;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign hs_req    = req_valid && req_ready;
    assign done      = (state == ACCESS) && PREADY;
    assign abort     = (state == ACCESS) && !PREADY && expired;

    cmsdk_apb_master_wdog u_wdog (
        .PCLK           (PCLK),
        .PRESET         (PRESET),
        .clear          (hs_req),
        .cnt_en         ((state == ACCESS) && !PREADY),
        .timeout_cycles (TMO),
        .expired        (expired)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (hs_req)         next_state = SETUP;
            SETUP:                       next_state = ACCESS;
            ACCESS:  if (done || abort)  next_state = RESP;
            RESP:    if (rsp_ready)      next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with the state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            PSEL      <= (next_state == SETUP) || (next_state == ACCESS);
            PENABLE   <= (next_state == ACCESS);
            rsp_valid <= (next_state == RESP);
        end
    end

    // Address/data only move at the command handshake, so they never toggle while PSEL is low.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (hs_req) begin
            PADDR  <= req_addr & ~ADDR_WIDTH'(3);
            PWRITE <= req_write;
            PWDATA <= req_wdata;
        end
    end

    // Completion wins over abort when PREADY rises on the expiry cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule
